rename_ckpt: RTL and testbench

Multi-checkpoint register-rename stage for the single-issue RV32 out-of-order core, placed between decode and dispatch. It maps architectural to physical registers through a RAT, a circular free list and a physical ready table. It supports up to NUM_CKPT unresolved branches, each with its own RAT and free-list snapshot. Physical registers are freed at commit from the previous mapping carried with the instruction, and ready bits are set at writeback rather than at commit.

---
 rtl/rename_pkg.sv | 25 ++
 rtl/rename_freelist.sv | 48 ++++
 rtl/rename_ckpt.sv | 147 ++++++++++++++
 tb/tb_rename_ckpt.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared sizing, pointer types and checkpoint layout for the rename stage.
package rename_pkg;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned NUM_CKPT  = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned P_IDX_W = idx_width(PHYS_REGS);
    localparam int unsigned CKPT_W  = idx_width(NUM_CKPT);
    localparam int unsigned A_IDX_W = idx_width(ARCH_REGS);

    typedef logic [P_IDX_W-1:0] preg_t;
    // One extra bit so that full and empty are distinguishable.
    typedef logic [P_IDX_W:0]   fptr_t;

    typedef struct packed {
        preg_t [ARCH_REGS-1:0] rat;
        fptr_t                 free_head;
    } ckpt_t;

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical registers with head snapshot and restore.
// PHYS_REGS is assumed to be a power of two so pointer wrap is free.
module rename_freelist
    import rename_pkg::*;
(
    input  logic  clk,
    input  logic  rst_ni,
    input  logic  push_i,
    input  preg_t push_data_i,
    input  logic  pop_i,
    input  logic  restore_i,
    input  fptr_t restore_head_i,
    output preg_t head_data_o,
    output fptr_t head_o,
    output fptr_t count_o
);

    preg_t [PHYS_REGS-1:0] mem_q;
    fptr_t                 head_q, head_d;
    fptr_t                 tail_q, tail_d;

    // Restore and pop are mutually exclusive: rename stalls on a mispredict.
    always_comb begin
        head_d = restore_i ? restore_head_i : head_q + fptr_t'(pop_i);
        tail_d = tail_q + fptr_t'(push_i);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem_q[i] <= (i < PHYS_REGS - ARCH_REGS) ? preg_t'(ARCH_REGS + i) : '0;
            end
            head_q <= '0;
            tail_q <= fptr_t'(PHYS_REGS - ARCH_REGS);
        end else begin
            if (push_i) begin
                mem_q[tail_q[P_IDX_W-1:0]] <= push_data_i;
            end
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_data_o = mem_q[head_q[P_IDX_W-1:0]];
    assign head_o      = head_q;
    assign count_o     = tail_q - head_q;

endmodule

// File: rtl/rename_ckpt.sv
// Register rename with RAT, free list, ready table and per-branch checkpoints.
// Define RENAME_WB_BYPASS_EN to forward same-cycle writeback into source ready.
module rename_ckpt
    import rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 dec_valid_i,
    input  logic                 dec_rs1_valid_i,
    input  logic                 dec_rs2_valid_i,
    input  logic [A_IDX_W-1:0]   dec_rs1_i,
    input  logic [A_IDX_W-1:0]   dec_rs2_i,
    input  logic [A_IDX_W-1:0]   dec_rd_i,
    input  logic                 dec_rd_valid_i,
    input  logic                 dec_is_branch_i,
    input  logic                 wb_valid_i,
    input  logic [P_IDX_W-1:0]   wb_preg_i,
    input  logic                 cm_valid_i,
    input  logic [P_IDX_W-1:0]   cm_rd_old_i,
    input  logic                 br_valid_i,
    input  logic [CKPT_W-1:0]    br_tag_i,
    input  logic                 br_mispredict_i,
    output logic                 rn_valid_o,
    output logic [P_IDX_W-1:0]   rn_rs1_o,
    output logic [P_IDX_W-1:0]   rn_rs2_o,
    output logic                 rn_rs1_ready_o,
    output logic                 rn_rs2_ready_o,
    output logic                 rn_rd_valid_o,
    output logic [P_IDX_W-1:0]   rn_rd_o,
    output logic [P_IDX_W-1:0]   rn_rd_old_o,
    output logic [CKPT_W-1:0]    rn_br_tag_o,
    output logic                 rn_full_o
);

    preg_t [ARCH_REGS-1:0] rat_q, rat_d;
    logic  [PHYS_REGS-1:0] ready_q, ready_d;
    ckpt_t                 ckpt_q [NUM_CKPT];
    ckpt_t                 snap;
    logic  [CKPT_W-1:0]    ck_head_q, ck_head_d, ck_tail_q, ck_tail_d;
    logic  [CKPT_W:0]      ck_count_q, ck_count_d;

    preg_t fl_head_data;
    fptr_t fl_head, fl_count;

    logic  alloc_needed, ckpt_full, stall, accept, do_alloc, ckpt_push;
    logic  br_match, br_restore, br_retire;
    preg_t rs1_p, rs2_p;
    logic  rs1_byp, rs2_byp;

    assign alloc_needed = dec_valid_i & dec_rd_valid_i & (dec_rd_i != '0);
    assign ckpt_full    = (ck_count_q == (CKPT_W+1)'(NUM_CKPT));
    // Resolves arrive in order; anything not aimed at the oldest live slot is dropped.
    assign br_match     = br_valid_i & (br_tag_i == ck_head_q) & (ck_count_q != '0);
    assign br_restore   = br_match & br_mispredict_i;
    assign br_retire    = br_match & ~br_mispredict_i;

    assign stall     = dec_valid_i & ((alloc_needed & (fl_count == '0)) |
                                      (dec_is_branch_i & ckpt_full) |
                                      (br_valid_i & br_mispredict_i));
    assign accept    = dec_valid_i & ~stall;
    assign do_alloc  = accept & alloc_needed;
    assign ckpt_push = accept & dec_is_branch_i;

    rename_freelist u_freelist (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .push_i         (cm_valid_i & (cm_rd_old_i != '0)),
        .push_data_i    (cm_rd_old_i),
        .pop_i          (do_alloc),
        .restore_i      (br_restore),
        .restore_head_i (ckpt_q[br_tag_i].free_head),
        .head_data_o    (fl_head_data),
        .head_o         (fl_head),
        .count_o        (fl_count)
    );

    always_comb begin
        rat_d = rat_q;
        if (br_restore) begin
            rat_d = ckpt_q[br_tag_i].rat;
        end else if (do_alloc) begin
            rat_d[dec_rd_i] = fl_head_data;
        end

        // Allocation clear is applied last so it beats a same-cycle writeback.
        ready_d = ready_q;
        if (wb_valid_i) ready_d[wb_preg_i] = 1'b1;
        if (do_alloc) ready_d[fl_head_data] = 1'b0;

        snap.rat       = rat_d;
        snap.free_head = fl_head + fptr_t'(do_alloc);

        ck_head_d  = ck_head_q + CKPT_W'(br_retire);
        ck_tail_d  = ck_tail_q + CKPT_W'(ckpt_push);
        ck_count_d = ck_count_q + (CKPT_W+1)'(ckpt_push) - (CKPT_W+1)'(br_retire);
        if (br_restore) begin
            ck_tail_d  = ck_head_q;
            ck_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= preg_t'(i);
            for (int i = 0; i < NUM_CKPT; i++) ckpt_q[i] <= '0;
            ready_q    <= '1;
            ck_head_q  <= '0;
            ck_tail_q  <= '0;
            ck_count_q <= '0;
        end else begin
            rat_q      <= rat_d;
            ready_q    <= ready_d;
            ck_head_q  <= ck_head_d;
            ck_tail_q  <= ck_tail_d;
            ck_count_q <= ck_count_d;
            if (ckpt_push) ckpt_q[ck_tail_q] <= snap;
        end
    end

    assign rs1_p = rat_q[dec_rs1_i];
    assign rs2_p = rat_q[dec_rs2_i];

`ifdef RENAME_WB_BYPASS_EN
    assign rs1_byp = wb_valid_i & (wb_preg_i == rs1_p);
    assign rs2_byp = wb_valid_i & (wb_preg_i == rs2_p);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    always_comb begin
        rn_valid_o     = accept;
        rn_full_o      = stall;
        rn_rs1_o       = (dec_valid_i & dec_rs1_valid_i) ? rs1_p : '0;
        rn_rs2_o       = (dec_valid_i & dec_rs2_valid_i) ? rs2_p : '0;
        rn_rs1_ready_o = dec_valid_i & (~dec_rs1_valid_i | ready_q[rs1_p] | rs1_byp);
        rn_rs2_ready_o = dec_valid_i & (~dec_rs2_valid_i | ready_q[rs2_p] | rs2_byp);
        rn_rd_valid_o  = do_alloc;
        rn_rd_o        = do_alloc ? fl_head_data : '0;
        rn_rd_old_o    = do_alloc ? rat_q[dec_rd_i] : '0;
        rn_br_tag_o    = '0;
        if (dec_valid_i) begin
            rn_br_tag_o = dec_is_branch_i ? ck_tail_q : ck_tail_q - CKPT_W'(1);
        end
    end

endmodule

// File: tb/tb_rename_ckpt.sv
// Self-checking bench for rename_ckpt: directed scenarios plus a randomized run
// against a queue-based model of mappings, free registers and checkpoints.
module tb_rename_ckpt;
    import rename_pkg::*;

    logic clk, rst_ni;
    logic dec_valid, dec_rs1_valid, dec_rs2_valid, dec_rd_valid, dec_is_branch;
    logic [A_IDX_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic wb_valid, cm_valid, br_valid, br_mispredict;
    logic [P_IDX_W-1:0] wb_preg, cm_rd_old;
    logic [CKPT_W-1:0] br_tag;
    logic rn_valid, rn_rs1_ready, rn_rs2_ready, rn_rd_valid, rn_full;
    logic [P_IDX_W-1:0] rn_rs1, rn_rs2, rn_rd, rn_rd_old;
    logic [CKPT_W-1:0] rn_br_tag;

    int total = 0;
    int bad = 0;

`ifdef RENAME_WB_BYPASS_EN
    localparam bit ByPass = 1'b1;
`else
    localparam bit ByPass = 1'b0;
`endif

    rename_ckpt dut (
        .clk(clk), .rst_ni(rst_ni),
        .dec_valid_i(dec_valid), .dec_rs1_valid_i(dec_rs1_valid),
        .dec_rs2_valid_i(dec_rs2_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
        .dec_rd_i(dec_rd), .dec_rd_valid_i(dec_rd_valid), .dec_is_branch_i(dec_is_branch),
        .wb_valid_i(wb_valid), .wb_preg_i(wb_preg),
        .cm_valid_i(cm_valid), .cm_rd_old_i(cm_rd_old),
        .br_valid_i(br_valid), .br_tag_i(br_tag), .br_mispredict_i(br_mispredict),
        .rn_valid_o(rn_valid), .rn_rs1_o(rn_rs1), .rn_rs2_o(rn_rs2),
        .rn_rs1_ready_o(rn_rs1_ready), .rn_rs2_ready_o(rn_rs2_ready),
        .rn_rd_valid_o(rn_rd_valid), .rn_rd_o(rn_rd), .rn_rd_old_o(rn_rd_old),
        .rn_br_tag_o(rn_br_tag), .rn_full_o(rn_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        dec_valid = 0; dec_rs1_valid = 0; dec_rs2_valid = 0; dec_rd_valid = 0;
        dec_is_branch = 0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        wb_valid = 0; wb_preg = '0; cm_valid = 0; cm_rd_old = '0;
        br_valid = 0; br_tag = '0; br_mispredict = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;
    endtask

    task automatic set_dec(input bit br, input bit rdv, input int rd,
                           input bit r1v, input int r1, input bit r2v, input int r2);
        dec_valid = 1; dec_is_branch = br; dec_rd_valid = rdv; dec_rd = A_IDX_W'(rd);
        dec_rs1_valid = r1v; dec_rs1 = A_IDX_W'(r1);
        dec_rs2_valid = r2v; dec_rs2 = A_IDX_W'(r2);
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        #2;
        total++; if (rn_valid !== 1'b0 || rn_full !== 1'b0 || rn_rd !== '0)
            begin bad++; $display("FAIL reset_idle_outs: valid=%b full=%b rd=%0d want 0 0 0",
                                  rn_valid, rn_full, rn_rd); end
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;
        #1;
        total++; if (rn_full !== 1'b0 || rn_rs1 !== '0 || rn_rs1_ready !== 1'b0)
            begin bad++; $display("FAIL reset_after_idle: full=%b rs1=%0d rdy=%b want 0 0 0",
                                  rn_full, rn_rs1, rn_rs1_ready); end
        set_dec(0, 0, 0, 1, 3, 0, 17);
        #1;
        total++; if (rn_rs1 !== 6'd3 || rn_rs1_ready !== 1'b1 || rn_rs2 !== '0 ||
                     rn_rs2_ready !== 1'b1 || rn_valid !== 1'b1 || rn_rd_valid !== 1'b0)
            begin bad++; $display("FAIL reset_identity: rs1=%0d r=%b rs2=%0d r=%b v=%b rdv=%b want 3 1 0 1 1 0",
                                  rn_rs1, rn_rs1_ready, rn_rs2, rn_rs2_ready, rn_valid, rn_rd_valid); end
        tick();
        idle();
    endtask

    task automatic test_basic();
        do_reset();
        set_dec(0, 1, 5, 1, 1, 1, 2);
        #1;
        total++; if (rn_valid !== 1'b1 || rn_rd_valid !== 1'b1 || rn_rd !== 6'd32 || rn_rd_old !== 6'd5)
            begin bad++; $display("FAIL basic_dest: v=%b rdv=%b rd=%0d old=%0d want 1 1 32 5",
                                  rn_valid, rn_rd_valid, rn_rd, rn_rd_old); end
        total++; if (rn_rs1 !== 6'd1 || rn_rs2 !== 6'd2 || rn_rs1_ready !== 1'b1 || rn_rs2_ready !== 1'b1)
            begin bad++; $display("FAIL basic_src: rs1=%0d rs2=%0d r=%b%b want 1 2 11",
                                  rn_rs1, rn_rs2, rn_rs1_ready, rn_rs2_ready); end
        tick();
        set_dec(0, 1, 6, 1, 5, 0, 0);
        #1;
        total++; if (rn_rs1 !== 6'd32 || rn_rs1_ready !== 1'b0 || rn_rd !== 6'd33 || rn_rd_old !== 6'd6)
            begin bad++; $display("FAIL basic_dep: rs1=%0d r=%b rd=%0d old=%0d want 32 0 33 6",
                                  rn_rs1, rn_rs1_ready, rn_rd, rn_rd_old); end
        tick();
        set_dec(0, 1, 0, 0, 0, 0, 0);
        #1;
        total++; if (rn_valid !== 1'b1 || rn_rd_valid !== 1'b0 || rn_rd !== '0 || rn_rd_old !== '0)
            begin bad++; $display("FAIL basic_x0: v=%b rdv=%b rd=%0d old=%0d want 1 0 0 0",
                                  rn_valid, rn_rd_valid, rn_rd, rn_rd_old); end
        tick();
        idle();
    endtask

    task automatic test_free_exhaust();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            set_dec(0, 1, 1 + (i % 31), 0, 0, 0, 0);
            #1;
            if (rn_valid !== 1'b1 || rn_rd !== preg_t'(32 + i)) errs++;
            tick();
        end
        total++; if (errs != 0)
            begin bad++; $display("FAIL exhaust_seq: %0d wrong allocations, want 0", errs); end
        set_dec(0, 1, 3, 0, 0, 0, 0);
        cm_valid = 1; cm_rd_old = 6'd5;
        #1;
        total++; if (rn_full !== 1'b1 || rn_valid !== 1'b0 || rn_rd_valid !== 1'b0)
            begin bad++; $display("FAIL exhaust_stall: full=%b v=%b rdv=%b want 1 0 0",
                                  rn_full, rn_valid, rn_rd_valid); end
        tick();
        cm_valid = 0;
        #1;
        total++; if (rn_full !== 1'b0 || rn_valid !== 1'b1 || rn_rd !== 6'd5)
            begin bad++; $display("FAIL exhaust_reuse: full=%b v=%b rd=%0d want 0 1 5",
                                  rn_full, rn_valid, rn_rd); end
        tick();
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        set_dec(1, 1, 1, 0, 0, 0, 0);
        #1;
        total++; if (rn_valid !== 1'b1 || rn_br_tag !== 2'd0 || rn_rd !== 6'd32)
            begin bad++; $display("FAIL mp_branch: v=%b tag=%0d rd=%0d want 1 0 32",
                                  rn_valid, rn_br_tag, rn_rd); end
        tick();
        set_dec(0, 1, 7, 0, 0, 0, 0);
        #1;
        total++; if (rn_rd !== 6'd33 || rn_rd_old !== 6'd7)
            begin bad++; $display("FAIL mp_shadow: rd=%0d old=%0d want 33 7", rn_rd, rn_rd_old); end
        tick();
        set_dec(0, 1, 8, 1, 7, 1, 1);
        br_valid = 1; br_tag = 2'd0; br_mispredict = 1;
        #1;
        total++; if (rn_full !== 1'b1 || rn_valid !== 1'b0)
            begin bad++; $display("FAIL mp_stall: full=%b v=%b want 1 0", rn_full, rn_valid); end
        tick();
        br_valid = 0; br_mispredict = 0;
        #1;
        total++; if (rn_rs1 !== 6'd7 || rn_rs2 !== 6'd32 || rn_rd !== 6'd33 || rn_valid !== 1'b1)
            begin bad++; $display("FAIL mp_restore: rs1=%0d rs2=%0d rd=%0d v=%b want 7 32 33 1",
                                  rn_rs1, rn_rs2, rn_rd, rn_valid); end
        tick();
        idle();
    endtask

    task automatic test_ckpt_full();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            set_dec(1, 0, 0, 0, 0, 0, 0);
            #1;
            if (rn_valid !== 1'b1 || rn_br_tag !== CKPT_W'(i)) errs++;
            tick();
        end
        total++; if (errs != 0)
            begin bad++; $display("FAIL ckpt_tags: %0d wrong tags, want 0", errs); end
        set_dec(1, 0, 0, 0, 0, 0, 0);
        br_valid = 1; br_tag = 2'd0; br_mispredict = 0;
        #1;
        total++; if (rn_full !== 1'b1 || rn_valid !== 1'b0)
            begin bad++; $display("FAIL ckpt_full_stall: full=%b v=%b want 1 0", rn_full, rn_valid); end
        tick();
        br_valid = 0;
        #1;
        total++; if (rn_full !== 1'b0 || rn_valid !== 1'b1 || rn_br_tag !== 2'd0)
            begin bad++; $display("FAIL ckpt_wrap: full=%b v=%b tag=%0d want 0 1 0",
                                  rn_full, rn_valid, rn_br_tag); end
        tick();
        idle();
    endtask

    task automatic test_wb_bypass();
        do_reset();
        set_dec(0, 1, 5, 0, 0, 0, 0);
        tick();
        set_dec(0, 0, 0, 1, 5, 0, 0);
        wb_valid = 1; wb_preg = 6'd32;
        #1;
        total++; if (rn_rs1 !== 6'd32 || rn_rs1_ready !== ByPass)
            begin bad++; $display("FAIL wb_same_cycle: rs1=%0d rdy=%b want 32 %b",
                                  rn_rs1, rn_rs1_ready, ByPass); end
        tick();
        wb_valid = 0;
        #1;
        total++; if (rn_rs1_ready !== 1'b1)
            begin bad++; $display("FAIL wb_next_cycle: rdy=%b want 1", rn_rs1_ready); end
        set_dec(0, 1, 9, 0, 0, 0, 0);
        wb_valid = 1; wb_preg = 6'd33;
        tick();
        wb_valid = 0;
        set_dec(0, 0, 0, 1, 9, 0, 0);
        #1;
        total++; if (rn_rs1 !== 6'd33 || rn_rs1_ready !== 1'b0)
            begin bad++; $display("FAIL wb_clear_wins: rs1=%0d rdy=%b want 33 0",
                                  rn_rs1, rn_rs1_ready); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_dec(1, 1, 1, 0, 0, 0, 0); tick();
        set_dec(1, 1, 2, 0, 0, 0, 0); tick();
        set_dec(0, 1, 3, 0, 0, 0, 0); tick();
        set_dec(0, 1, 4, 0, 0, 0, 0);
        rst_ni = 0;
        #1;
        total++; if (rn_rd !== 6'd32 || rn_rd_old !== 6'd4)
            begin bad++; $display("FAIL reset_async: rd=%0d old=%0d want 32 4", rn_rd, rn_rd_old); end
        idle();
        tick();
        rst_ni = 1;
        set_dec(1, 1, 9, 1, 1, 1, 3);
        #1;
        total++; if (rn_full !== 1'b0 || rn_valid !== 1'b1 || rn_rs1 !== 6'd1 || rn_rs2 !== 6'd3 ||
                     rn_rd !== 6'd32 || rn_br_tag !== 2'd0)
            begin bad++; $display("FAIL reset_mid: full=%b v=%b rs1=%0d rs2=%0d rd=%0d tag=%0d want 0 1 1 3 32 0",
                                  rn_full, rn_valid, rn_rs1, rn_rs2, rn_rd, rn_br_tag); end
        tick();
        idle();
    endtask

    typedef struct packed { preg_t [ARCH_REGS-1:0] rat; int log_len; } snap_t;
    typedef struct packed { preg_t old; int idx; } pend_t;

    task automatic test_random();
        preg_t [ARCH_REGS-1:0] m_rat;
        bit    m_ready [PHYS_REGS];
        int    m_free [$];
        int    m_log [$];
        snap_t m_ck [$];
        pend_t m_pend [$];
        pend_t keep [$];
        int    m_tail, head_tag, limit, r1, r2, rd, wbp, btag, ll;
        bit    dv, r1v, r2v, rdv, isbr, wbv, cmv, bv, mp;
        bit    e_alloc, e_stall, e_acc, e_r1r, e_r2r, br_ok;
        preg_t e_rs1, e_rs2, e_rd, e_old, cmo;

        do_reset();
        for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = preg_t'(i);
        for (int i = 0; i < PHYS_REGS; i++) m_ready[i] = 1'b1;
        for (int i = ARCH_REGS; i < PHYS_REGS; i++) m_free.push_back(i);
        m_tail = 0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            dv = ($urandom % 4) != 0;
            r1v = $urandom % 2; r2v = $urandom % 2; rdv = ($urandom % 4) != 0;
            r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31); rd = $urandom_range(0, 31);
            isbr = ($urandom % 5) == 0;
            wbv = $urandom % 2; wbp = $urandom_range(0, PHYS_REGS - 1);
            limit = (m_ck.size() != 0) ? m_ck[0].log_len : 32'h7fff_ffff;
            cmv = 0; cmo = '0;
            if (m_pend.size() != 0 && m_pend[0].idx < limit && ($urandom % 3) != 0) begin
                cmv = 1; cmo = m_pend[0].old;
            end else if (($urandom % 8) == 0) begin
                cmv = 1;
            end
            head_tag = ((m_tail - m_ck.size()) % NUM_CKPT + NUM_CKPT) % NUM_CKPT;
            bv = (m_ck.size() != 0) && (($urandom % 5) == 0);
            mp = ($urandom % 4) == 0;
            btag = (($urandom % 8) == 0) ? (head_tag + 1) % NUM_CKPT : head_tag;

            if (dv) set_dec(isbr, rdv, rd, r1v, r1, r2v, r2);
            else begin
                dec_valid = 0; dec_is_branch = isbr; dec_rd_valid = rdv;
                dec_rs1_valid = r1v; dec_rs2_valid = r2v;
                dec_rs1 = A_IDX_W'(r1); dec_rs2 = A_IDX_W'(r2); dec_rd = A_IDX_W'(rd);
            end
            wb_valid = wbv; wb_preg = preg_t'(wbp);
            cm_valid = cmv; cm_rd_old = cmo;
            br_valid = bv; br_tag = CKPT_W'(btag); br_mispredict = mp;

            e_alloc = dv && rdv && (rd != 0);
            e_stall = dv && ((e_alloc && m_free.size() == 0) ||
                             (isbr && m_ck.size() == NUM_CKPT) || (bv && mp));
            e_acc   = dv && !e_stall;
            br_ok   = bv && (btag == head_tag);
            e_rs1   = (dv && r1v) ? m_rat[r1] : '0;
            e_rs2   = (dv && r2v) ? m_rat[r2] : '0;
            e_r1r   = dv && (!r1v || m_ready[m_rat[r1]] || (ByPass && wbv && wbp == int'(m_rat[r1])));
            e_r2r   = dv && (!r2v || m_ready[m_rat[r2]] || (ByPass && wbv && wbp == int'(m_rat[r2])));
            e_rd    = (e_acc && e_alloc) ? preg_t'(m_free[0]) : '0;
            e_old   = (e_acc && e_alloc) ? m_rat[rd] : '0;
            #1;

            total++; if (rn_valid !== e_acc || rn_full !== e_stall)
                begin bad++; $display("FAIL rand_handshake c%0d: v=%b full=%b want %b %b",
                                      cyc, rn_valid, rn_full, e_acc, e_stall); end
            total++; if (rn_rs1 !== e_rs1 || rn_rs1_ready !== e_r1r || rn_rs2 !== e_rs2 ||
                         rn_rs2_ready !== e_r2r)
                begin bad++; $display("FAIL rand_src c%0d: %0d/%b %0d/%b want %0d/%b %0d/%b",
                                      cyc, rn_rs1, rn_rs1_ready, rn_rs2, rn_rs2_ready,
                                      e_rs1, e_r1r, e_rs2, e_r2r); end
            total++; if (rn_rd_valid !== (e_acc && e_alloc) || rn_rd !== e_rd || rn_rd_old !== e_old)
                begin bad++; $display("FAIL rand_dst c%0d: rdv=%b rd=%0d old=%0d want %b %0d %0d",
                                      cyc, rn_rd_valid, rn_rd, rn_rd_old, e_acc && e_alloc, e_rd, e_old); end
            if (e_acc && isbr) begin
                total++; if (rn_br_tag !== CKPT_W'(m_tail))
                    begin bad++; $display("FAIL rand_tag c%0d: tag=%0d want %0d",
                                          cyc, rn_br_tag, m_tail); end
            end

            if (cmv && cmo != '0) begin
                m_free.push_back(int'(cmo));
                void'(m_pend.pop_front());
            end
            if (wbv) m_ready[wbp] = 1'b1;
            if (e_acc && e_alloc) begin
                m_pend.push_back('{old: m_rat[rd], idx: m_log.size()});
                m_log.push_back(m_free[0]);
                m_rat[rd] = preg_t'(m_free.pop_front());
                m_ready[m_rat[rd]] = 1'b0;
            end
            if (br_ok && mp) begin
                ll = m_ck[0].log_len;
                while (m_log.size() > ll) m_free.push_front(m_log.pop_back());
                keep.delete();
                foreach (m_pend[k]) if (m_pend[k].idx < ll) keep.push_back(m_pend[k]);
                m_pend = keep;
                m_rat = m_ck[0].rat;
                m_tail = head_tag;
                m_ck.delete();
            end else if (br_ok) begin
                void'(m_ck.pop_front());
            end
            if (e_acc && isbr) begin
                m_ck.push_back('{rat: m_rat, log_len: m_log.size()});
                m_tail = (m_tail + 1) % NUM_CKPT;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_ni = 1;
        #1;
        test_reset();
        test_basic();
        test_free_exhaust();
        test_mispredict();
        test_ckpt_full();
        test_wb_bypass();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
